// File: rtl/sd_dma_pkg.sv
// -----------------------------------------------------------------------------
// sd_dma_pkg : shared types and constants for the SD host ADMA data path
// Revision   : 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package sd_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } xfer_state_e;

  localparam logic CARD_TO_HOST    = 1'b1;
  localparam logic HOST_TO_CARD    = 1'b0;
  localparam int   BURST_BYTES_DEF = 64;
  // A descriptor length field of zero encodes the full 64 KiB.
  localparam int   DESC_LEN_ZERO   = 65536;

endpackage

`default_nettype wire

// File: rtl/adma_burst_sizer.sv
// -----------------------------------------------------------------------------
// adma_burst_sizer : combinational min() of descriptor remainder, block
//                    remainder and distance to the next burst boundary
// Revision         : 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module adma_burst_sizer #(
  parameter int BURST_BYTES = 64,
  parameter int BL_W        = $clog2(BURST_BYTES) + 1
) (
  input  logic [$clog2(BURST_BYTES)-1:0] i_addr_lo,
  input  logic [16:0]                    i_desc_rem,
  input  logic [11:0]                    i_blk_rem,
  output logic [BL_W-1:0]                o_len
);

  localparam logic [BL_W-1:0] c_burst_len = BL_W'(BURST_BYTES);

  logic [BL_W-1:0] w_dist;
  logic [BL_W-1:0] w_desc_c;
  logic [BL_W-1:0] w_blk_c;
  logic [BL_W-1:0] w_min_rem;

  assign w_dist    = c_burst_len - {1'b0, i_addr_lo};
  // Clamp the wide remainders first so the compare stays BL_W bits wide.
  assign w_desc_c  = (i_desc_rem > 17'(BURST_BYTES)) ? c_burst_len : i_desc_rem[BL_W-1:0];
  assign w_blk_c   = (i_blk_rem  > 12'(BURST_BYTES)) ? c_burst_len : i_blk_rem[BL_W-1:0];
  assign w_min_rem = (w_desc_c < w_blk_c) ? w_desc_c : w_blk_c;
  assign o_len     = (w_min_rem < w_dist) ? w_min_rem : w_dist;

endmodule

`default_nettype wire

// File: rtl/adma_xfer_sequencer.sv
// -----------------------------------------------------------------------------
// adma_xfer_sequencer : splits ADMA TRAN descriptors into bus bursts, tracking
//                       block size/count and block-gap stop/continue
// Revision            : 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module adma_xfer_sequencer
  import sd_dma_pkg::*;
#(
  parameter int ADDR_W      = 64,
  parameter int BURST_BYTES = BURST_BYTES_DEF,
  parameter int BL_W        = $clog2(BURST_BYTES) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              desc_valid,
  output logic              desc_ready,
  input  logic [ADDR_W-1:0] desc_addr,
  input  logic [15:0]       desc_len,
  input  logic              desc_end,
  input  logic              dir,
  input  logic [11:0]       blk_size,
  input  logic [15:0]       blk_cnt,
  input  logic              blk_cnt_en,
  input  logic              multi_blk,
  input  logic              stop_at_gap,
  input  logic              continue_req,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [BL_W-1:0]   bus_len,
  output logic              bus_wr,
  input  logic              bus_done,
  output logic              tfc,
  output logic              xfer_complete,
  output logic              blk_gap_evt,
  output logic              adma_err,
  output logic              busy,
  output logic [15:0]       blocks_left
);

  localparam int OFS_W = $clog2(BURST_BYTES);

  xfer_state_e       r_state, w_nx_state;
  logic [ADDR_W-1:0] r_cur_addr, w_nx_addr;
  logic [16:0]       r_desc_rem, w_nx_desc_rem;
  logic [11:0]       r_blk_rem, w_nx_blk_rem;
  logic [15:0]       r_blocks_left, w_nx_blocks_left;
  logic [BL_W-1:0]   r_bus_len, w_nx_bus_len, w_size;
  logic              r_in_xfer, w_nx_in_xfer;
  logic              r_end_l, w_nx_end_l;
  logic              r_dir, w_nx_dir;
  logic              r_bus_req, r_desc_ready;
  logic              r_tfc, w_tfc;
  logic              r_xc, w_xc;
  logic              r_gap, w_gap;
  logic              r_err, w_err;

  logic [ADDR_W-1:0] w_addr_after;
  logic [16:0]       w_desc_after;
  logic [11:0]       w_blk_after;
  logic              w_cfg_bad;
  logic              w_last;

  assign w_addr_after = r_cur_addr + {{(ADDR_W-BL_W){1'b0}}, r_bus_len};
  assign w_desc_after = r_desc_rem - {{(17-BL_W){1'b0}}, r_bus_len};
  assign w_blk_after  = r_blk_rem  - {{(12-BL_W){1'b0}}, r_bus_len};
  assign w_cfg_bad    = (blk_size == 12'd0) || (blk_cnt_en && (blk_cnt == 16'd0));
  assign w_last       = !multi_blk || (blk_cnt_en && (r_blocks_left == 16'd1)) ||
                        (r_end_l && (w_desc_after == 17'd0));

  // Sized from the next-state values so bus_len is valid on the first ISSUE cycle.
  adma_burst_sizer #(
    .BURST_BYTES (BURST_BYTES),
    .BL_W        (BL_W)
  ) u_sizer (
    .i_addr_lo  (w_nx_addr[OFS_W-1:0]),
    .i_desc_rem (w_nx_desc_rem),
    .i_blk_rem  (w_nx_blk_rem),
    .o_len      (w_size)
  );

  assign w_nx_bus_len = (w_nx_state == ST_ISSUE) ? w_size : r_bus_len;

  always_comb begin
    w_nx_state       = r_state;
    w_nx_addr        = r_cur_addr;
    w_nx_desc_rem    = r_desc_rem;
    w_nx_blk_rem     = r_blk_rem;
    w_nx_blocks_left = r_blocks_left;
    w_nx_in_xfer     = r_in_xfer;
    w_nx_end_l       = r_end_l;
    w_nx_dir         = r_dir;
    w_tfc            = 1'b0;
    w_xc             = 1'b0;
    w_gap            = 1'b0;
    w_err            = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (desc_valid) begin
          w_nx_addr     = desc_addr;
          w_nx_desc_rem = (desc_len == 16'd0) ? 17'(DESC_LEN_ZERO) : {1'b0, desc_len};
          w_nx_end_l    = desc_end;
          if (!r_in_xfer) begin
            w_nx_dir         = (dir == CARD_TO_HOST);
            w_nx_blk_rem     = blk_size;
            w_nx_blocks_left = blk_cnt;
            if (w_cfg_bad) begin
              w_err = 1'b1;
            end else begin
              w_nx_in_xfer = 1'b1;
              w_nx_state   = ST_ISSUE;
            end
          end else begin
            w_nx_state = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        if (bus_gnt) w_nx_state = ST_WAIT_DONE;
      end

      ST_WAIT_DONE: begin
        if (bus_done) begin
          w_nx_addr     = w_addr_after;
          w_nx_desc_rem = w_desc_after;
          w_nx_blk_rem  = w_blk_after;
          w_nx_state    = ST_ISSUE;
          if (w_blk_after == 12'd0) begin
            if (blk_cnt_en) w_nx_blocks_left = r_blocks_left - 16'd1;
            if (w_last) begin
              // Any bytes still left in the descriptor are dropped here.
              w_tfc        = 1'b1;
              w_xc         = 1'b1;
              w_nx_in_xfer = 1'b0;
              w_nx_state   = ST_IDLE;
            end else if (stop_at_gap) begin
              w_gap      = 1'b1;
              w_tfc      = (w_desc_after == 17'd0);
              w_nx_state = ST_GAP;
            end else begin
              w_nx_blk_rem = blk_size;
              if (w_desc_after == 17'd0) begin
                w_tfc      = 1'b1;
                w_nx_state = ST_IDLE;
              end
            end
          end else if (w_desc_after == 17'd0) begin
            // Descriptor ran out mid-block: fine unless it was the last one.
            w_tfc      = 1'b1;
            w_nx_state = ST_IDLE;
            if (r_end_l) begin
              w_err        = 1'b1;
              w_nx_in_xfer = 1'b0;
            end
          end
        end
      end

      ST_GAP: begin
        if (continue_req && !stop_at_gap) begin
          w_nx_blk_rem = blk_size;
          w_nx_state   = (r_desc_rem != 17'd0) ? ST_ISSUE : ST_IDLE;
        end
      end

      default: w_nx_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cur_addr    <= '0;
      r_desc_rem    <= '0;
      r_blk_rem     <= '0;
      r_blocks_left <= '0;
      r_bus_len     <= '0;
      r_in_xfer     <= 1'b0;
      r_end_l       <= 1'b0;
      r_dir         <= 1'b0;
      r_bus_req     <= 1'b0;
      r_desc_ready  <= 1'b1;
      r_tfc         <= 1'b0;
      r_xc          <= 1'b0;
      r_gap         <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_nx_state;
      r_cur_addr    <= w_nx_addr;
      r_desc_rem    <= w_nx_desc_rem;
      r_blk_rem     <= w_nx_blk_rem;
      r_blocks_left <= w_nx_blocks_left;
      r_bus_len     <= w_nx_bus_len;
      r_in_xfer     <= w_nx_in_xfer;
      r_end_l       <= w_nx_end_l;
      r_dir         <= w_nx_dir;
      r_bus_req     <= (w_nx_state == ST_ISSUE);
      r_desc_ready  <= (w_nx_state == ST_IDLE);
      r_tfc         <= w_tfc;
      r_xc          <= w_xc;
      r_gap         <= w_gap;
      r_err         <= w_err;
    end
  end

  assign desc_ready    = r_desc_ready;
  assign bus_req       = r_bus_req;
  assign bus_addr      = r_cur_addr;
  assign bus_len       = r_bus_len;
  assign bus_wr        = r_dir;
  assign tfc           = r_tfc;
  assign xfer_complete = r_xc;
  assign blk_gap_evt   = r_gap;
  assign adma_err      = r_err;
  assign busy          = r_in_xfer;
  assign blocks_left   = r_blocks_left;

endmodule

`default_nettype wire

// File: tb/tb_adma_xfer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_adma_xfer_sequencer : directed, table-driven bench for adma_xfer_sequencer
// Revision               : 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_adma_xfer_sequencer;

  localparam int ADDR_W = 64;
  localparam int BB     = 64;
  localparam int BL_W   = 7;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              desc_valid = 1'b0;
  logic              desc_ready;
  logic [ADDR_W-1:0] desc_addr = '0;
  logic [15:0]       desc_len = '0;
  logic              desc_end = 1'b0;
  logic              dir = 1'b0;
  logic [11:0]       blk_size = '0;
  logic [15:0]       blk_cnt = '0;
  logic              blk_cnt_en = 1'b0;
  logic              multi_blk = 1'b0;
  logic              stop_at_gap = 1'b0;
  logic              continue_req = 1'b0;
  logic              bus_req;
  logic              bus_gnt = 1'b0;
  logic [ADDR_W-1:0] bus_addr;
  logic [BL_W-1:0]   bus_len;
  logic              bus_wr;
  logic              bus_done = 1'b0;
  logic              tfc, xfer_complete, blk_gap_evt, adma_err, busy;
  logic [15:0]       blocks_left;

  always #5 clk = ~clk;

  adma_xfer_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .desc_valid    (desc_valid),
    .desc_ready    (desc_ready),
    .desc_addr     (desc_addr),
    .desc_len      (desc_len),
    .desc_end      (desc_end),
    .dir           (dir),
    .blk_size      (blk_size),
    .blk_cnt       (blk_cnt),
    .blk_cnt_en    (blk_cnt_en),
    .multi_blk     (multi_blk),
    .stop_at_gap   (stop_at_gap),
    .continue_req  (continue_req),
    .bus_req       (bus_req),
    .bus_gnt       (bus_gnt),
    .bus_addr      (bus_addr),
    .bus_len       (bus_len),
    .bus_wr        (bus_wr),
    .bus_done      (bus_done),
    .tfc           (tfc),
    .xfer_complete (xfer_complete),
    .blk_gap_evt   (blk_gap_evt),
    .adma_err      (adma_err),
    .busy          (busy),
    .blocks_left   (blocks_left)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Observed bus activity and pulse counts
  int          n_bursts = 0;
  int          n_viol = 0;
  int          c_tfc = 0, c_xc = 0, c_gap = 0, c_err = 0;
  logic [63:0] last_addr = '0;
  int          last_len = 0;
  logic        last_wr = 1'b0;
  logic [63:0] baddr[$];
  logic        resp_en = 1'b1;
  int          ph = 0;

  // Bus responder: grant one cycle, then done one cycle later.
  always @(negedge clk) begin
    if (!rst_n) begin
      bus_gnt  = 1'b0;
      bus_done = 1'b0;
      ph       = 0;
    end else begin
      if (tfc)           c_tfc++;
      if (xfer_complete) c_xc++;
      if (blk_gap_evt)   c_gap++;
      if (adma_err)      c_err++;
      case (ph)
        0: if (bus_req && resp_en) begin
          n_bursts++;
          last_addr = bus_addr;
          last_len  = int'(bus_len);
          last_wr   = bus_wr;
          baddr.push_back(bus_addr);
          if (bus_len == '0 || int'(bus_len) > BB || (int'(bus_addr[5:0]) + int'(bus_len)) > BB)
            n_viol++;
          bus_gnt = 1'b1;
          ph      = 1;
        end
        1: begin
          bus_gnt  = 1'b0;
          bus_done = 1'b1;
          ph       = 2;
        end
        default: begin
          bus_done = 1'b0;
          ph       = 0;
        end
      endcase
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic clear_obs();
    n_bursts  = 0;
    n_viol    = 0;
    c_tfc     = 0;
    c_xc      = 0;
    c_gap     = 0;
    c_err     = 0;
    last_addr = '0;
    last_len  = 0;
    baddr.delete();
  endtask

  task automatic send_desc(input logic [63:0] a, input logic [15:0] l, input logic e);
    @(negedge clk);
    desc_addr  = a;
    desc_len   = l;
    desc_end   = e;
    desc_valid = 1'b1;
    @(negedge clk);
    desc_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!desc_ready && k < 20000);
    chk({nm, "_idle"}, 64'(desc_ready), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic [63:0] addr;
    logic [15:0] len;
    logic        dend;
    logic [11:0] bsz;
    logic [15:0] bcnt;
    logic        cnt_en;
    logic        multi;
    int          exp_bursts;
    logic [63:0] exp_last_addr;
    int          exp_last_len;
    int          exp_tfc;
    int          exp_xc;
    int          exp_err;
    logic [15:0] exp_bl;  // 16'hFFFF: not checked
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input int i);
    vec_t  v;
    string p;
    v = vecs[i];
    p = $sformatf("v%0d", i);
    blk_size    = v.bsz;
    blk_cnt     = v.bcnt;
    blk_cnt_en  = v.cnt_en;
    multi_blk   = v.multi;
    stop_at_gap = 1'b0;
    dir         = i[0];
    clear_obs();
    send_desc(v.addr, v.len, v.dend);
    wait_idle(p);
    chk({p, "_bursts"},    64'(n_bursts), 64'(v.exp_bursts));
    chk({p, "_last_addr"}, last_addr,     v.exp_last_addr);
    chk({p, "_last_len"},  64'(last_len), 64'(v.exp_last_len));
    chk({p, "_tfc"},       64'(c_tfc),    64'(v.exp_tfc));
    chk({p, "_xc"},        64'(c_xc),     64'(v.exp_xc));
    chk({p, "_err"},       64'(c_err),    64'(v.exp_err));
    chk({p, "_gap"},       64'(c_gap),    64'd0);
    chk({p, "_bound"},     64'(n_viol),   64'd0);
    chk({p, "_busy"},      64'(busy),     64'd0);
    if (v.exp_bl != 16'hFFFF) chk({p, "_blocks_left"}, 64'(blocks_left), 64'(v.exp_bl));
    if (v.exp_bursts > 0)     chk({p, "_bus_wr"}, 64'(last_wr), 64'(i[0]));
  endtask

  initial begin
    int rq;

    vecs[0] = '{64'h1000,  16'd512, 1'b1, 12'd512, 16'd1, 1'b0, 1'b0, 8,    64'h11C0,  64, 1, 1, 0, 16'd1};
    vecs[1] = '{64'h1030,  16'd100, 1'b1, 12'd512, 16'd1, 1'b0, 1'b0, 3,    64'h1080,  20, 1, 0, 1, 16'd1};
    vecs[2] = '{64'h2010,  16'd200, 1'b0, 12'd64,  16'd1, 1'b0, 1'b0, 2,    64'h2040,  16, 1, 1, 0, 16'd1};
    vecs[3] = '{64'h2000,  16'd64,  1'b1, 12'd0,   16'd1, 1'b0, 1'b0, 0,    64'h0,     0,  0, 0, 1, 16'hFFFF};
    vecs[4] = '{64'h2000,  16'd64,  1'b1, 12'd512, 16'd0, 1'b1, 1'b1, 0,    64'h0,     0,  0, 0, 1, 16'hFFFF};
    vecs[5] = '{64'h3000,  16'd64,  1'b0, 12'd32,  16'd2, 1'b1, 1'b1, 2,    64'h3020,  32, 1, 1, 0, 16'd0};
    vecs[6] = '{64'h4000,  16'd96,  1'b1, 12'd48,  16'd5, 1'b0, 1'b1, 3,    64'h4040,  32, 1, 1, 0, 16'd5};
    vecs[7] = '{64'h10000, 16'd0,   1'b1, 12'd64,  16'd1, 1'b0, 1'b1, 1024, 64'h1FFC0, 64, 1, 1, 0, 16'd1};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_desc_ready",  64'(desc_ready),  64'd1);
    chk("rst_bus_req",     64'(bus_req),     64'd0);
    chk("rst_busy",        64'(busy),        64'd0);
    chk("rst_blocks_left", 64'(blocks_left), 64'd0);
    chk("rst_bus_len",     64'(bus_len),     64'd0);
    chk("rst_bus_addr",    bus_addr,         64'd0);
    chk("rst_bus_wr",      64'(bus_wr),      64'd0);
    chk("rst_pulses",      64'({tfc, xfer_complete, blk_gap_evt, adma_err}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_desc_ready", 64'(desc_ready), 64'd1);

    for (int i = 0; i < 8; i++) run_vec(i);

    // Two descriptors forming three counted blocks
    blk_size = 12'd128; blk_cnt = 16'd3; blk_cnt_en = 1'b1; multi_blk = 1'b1;
    stop_at_gap = 1'b0; dir = 1'b1;
    clear_obs();
    send_desc(64'h5000, 16'd256, 1'b0);
    wait_idle("mb1");
    chk("mb1_bursts",      64'(n_bursts),    64'd4);
    chk("mb1_last_addr",   last_addr,        64'h50C0);
    chk("mb1_tfc",         64'(c_tfc),       64'd1);
    chk("mb1_xc",          64'(c_xc),        64'd0);
    chk("mb1_blocks_left", 64'(blocks_left), 64'd1);
    chk("mb1_busy",        64'(busy),        64'd1);
    clear_obs();
    send_desc(64'h6000, 16'd128, 1'b1);
    wait_idle("mb2");
    chk("mb2_bursts",      64'(n_bursts),    64'd2);
    chk("mb2_last_addr",   last_addr,        64'h6040);
    chk("mb2_tfc",         64'(c_tfc),       64'd1);
    chk("mb2_xc",          64'(c_xc),        64'd1);
    chk("mb2_blocks_left", 64'(blocks_left), 64'd0);
    chk("mb2_busy",        64'(busy),        64'd0);

    // Stop at block gap, ignored continue, then resume
    blk_size = 12'd128; blk_cnt = 16'd2; blk_cnt_en = 1'b1; multi_blk = 1'b1;
    stop_at_gap = 1'b1; dir = 1'b0;
    clear_obs();
    send_desc(64'h7000, 16'd256, 1'b1);
    rq = 0;
    while (c_gap == 0 && rq < 2000) begin
      @(negedge clk);
      rq++;
    end
    chk("gap_evt",    64'(c_gap),    64'd1);
    chk("gap_bursts", 64'(n_bursts), 64'd2);
    chk("gap_tfc",    64'(c_tfc),    64'd0);
    rq = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus_req) rq++;
    end
    chk("gap_req_held_low", 64'(rq),         64'd0);
    chk("gap_desc_ready",   64'(desc_ready), 64'd0);
    @(negedge clk) continue_req = 1'b1;
    @(negedge clk) continue_req = 1'b0;
    repeat (5) @(negedge clk);
    chk("gap_ignored_continue", 64'(n_bursts), 64'd2);
    stop_at_gap = 1'b0;
    @(negedge clk) continue_req = 1'b1;
    @(negedge clk) continue_req = 1'b0;
    wait_idle("gap_resume");
    chk("gap_resume_bursts", 64'(n_bursts), 64'd4);
    if (baddr.size() > 2) chk("gap_resume_addr", baddr[2], 64'h7080);
    chk("gap_resume_xc",   64'(c_xc),        64'd1);
    chk("gap_resume_tfc",  64'(c_tfc),       64'd1);
    chk("gap_resume_bl",   64'(blocks_left), 64'd0);
    chk("gap_resume_busy", 64'(busy),        64'd0);

    // Reset while a burst request is outstanding
    blk_size = 12'd512; blk_cnt = 16'd7; blk_cnt_en = 1'b1; multi_blk = 1'b1;
    resp_en = 1'b0;
    clear_obs();
    send_desc(64'h8000, 16'd512, 1'b1);
    repeat (3) @(negedge clk);
    chk("pre_rst_bus_req",     64'(bus_req),     64'd1);
    chk("pre_rst_blocks_left", 64'(blocks_left), 64'd7);
    chk("pre_rst_busy",        64'(busy),        64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_bus_req",     64'(bus_req),     64'd0);
    chk("async_rst_desc_ready",  64'(desc_ready),  64'd1);
    chk("async_rst_blocks_left", 64'(blocks_left), 64'd0);
    chk("async_rst_busy",        64'(busy),        64'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    resp_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rel_desc_ready", 64'(desc_ready), 64'd1);
    chk("rel_bus_req",    64'(bus_req),    64'd0);
    chk("rel_pulses",     64'(c_tfc + c_xc + c_gap + c_err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
